// File: rtl/img_loader_pkg.sv
// Shared types and widths for the image loader: the FSM state encoding and
// the SRAM / pixel geometry used by image_loader and pixel_packer.
package img_loader_pkg;

   localparam int ADDR_W       = 12;
   localparam int DATA_W       = 32;
   localparam int PIX_W        = 8;
   localparam int PIX_PER_WORD = 4;
   localparam int LANE_W       = $clog2(PIX_PER_WORD);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } loader_state_t;

endpackage

// File: rtl/pixel_packer.sv
// Byte-lane packer: inserts each accepted pixel into the next lane of a
// 32-bit word (lane 0 = bits [7:0]). word_ready pulses in the cycle the
// word completes, either on its 4th byte or early on flush. Lanes above
// the flushed pixel are already zero because the register clears after
// every emitted word, so an early flush comes out zero-padded.
module pixel_packer
   import img_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              push,
   input  logic [PIX_W-1:0]  push_data,
   input  logic              flush,
   output logic              word_ready,
   output logic [DATA_W-1:0] word_data,
   output logic [LANE_W-1:0] byte_idx
);

   logic [DATA_W-1:0] pack_q;
   logic [LANE_W-1:0] lane_q;

   // Current word with the incoming pixel dropped into its lane
   always_comb begin
      word_data = pack_q;
      for (int i = 0; i < PIX_PER_WORD; i++) begin
         if (lane_q == LANE_W'(i)) begin
            word_data[i*PIX_W +: PIX_W] = push_data;
         end
      end
      word_ready = push && (flush || (lane_q == LANE_W'(PIX_PER_WORD - 1)));
   end

   // Pack register and lane counter; both restart after each emitted word
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pack_q <= '0;
         lane_q <= '0;
      end else if (clear) begin
         pack_q <= '0;
         lane_q <= '0;
      end else if (push) begin
         if (word_ready) begin
            pack_q <= '0;
            lane_q <= '0;
         end else begin
            pack_q <= word_data;
            lane_q <= lane_q + LANE_W'(1);
         end
      end
   end

   assign byte_idx = lane_q;

endmodule

// File: rtl/image_loader.sv
// Image loader: accepts an 8-bit pixel stream, packs four pixels per word
// and writes the words into the image-buffer SRAM starting at BUF_BASE.
// Flags image_buffer_valid once the image is stored and holds it until the
// hash engine reports hash_calc_done.
// Optional feature: define IMG_LOADER_CHECKSUM_EN to get a 16-bit
// wrap-around pixel sum on image_checksum; otherwise it is tied to zero.
module image_loader
   import img_loader_pkg::*;
#(
   parameter int                IMAGE_WORDS = 256,
   parameter logic [ADDR_W-1:0] BUF_BASE    = 12'h000
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              load_start,
   input  logic              pix_valid,
   input  logic [PIX_W-1:0]  pix_data,
   input  logic              pix_last,
   output logic              pix_ready,
   output logic [ADDR_W-1:0] buffer_A1,
   output logic [DATA_W-1:0] buffer_I1,
   output logic              buffer_WEB1,
   output logic              image_buffer_valid,
   input  logic              hash_calc_done,
   output logic              err_len,
   output logic [15:0]       image_checksum
);

   localparam int WIDX_W = ADDR_W + 1;

   loader_state_t     state_q, next_state;
   logic [WIDX_W-1:0] word_idx;
   logic              accept, is_final, end_image, set_err, start_load;
   logic              word_ready;
   logic [DATA_W-1:0] word_data;
   logic [LANE_W-1:0] byte_idx;

   pixel_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (start_load),
      .push       (accept),
      .push_data  (pix_data),
      .flush      (pix_last),
      .word_ready (word_ready),
      .word_data  (word_data),
      .byte_idx   (byte_idx)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= next_state;
      end
   end

   // Next-state logic and image-end / length-error detection
   always_comb begin
      next_state = state_q;
      start_load = (state_q == IDLE) && load_start;
      accept     = pix_valid && pix_ready;
      is_final   = (word_idx == WIDX_W'(IMAGE_WORDS - 1)) &&
                   (byte_idx == LANE_W'(PIX_PER_WORD - 1));
      end_image  = accept && (is_final || pix_last);
      set_err    = accept && (is_final != pix_last);
      unique case (state_q)
         IDLE:    if (load_start)     next_state = FILL;
         FILL:    if (end_image)      next_state = FLUSH;
         FLUSH:                       next_state = DONE;
         DONE:    if (hash_calc_done) next_state = IDLE;
         default:                     next_state = IDLE;
      endcase
   end

   // Registered outputs: handshake, SRAM write port, status flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pix_ready          <= 1'b0;
         buffer_A1          <= '0;
         buffer_I1          <= '0;
         buffer_WEB1        <= 1'b1;
         image_buffer_valid <= 1'b0;
         err_len            <= 1'b0;
         word_idx           <= '0;
      end else begin
         pix_ready          <= (next_state == FILL);
         buffer_WEB1        <= !word_ready;
         image_buffer_valid <= (state_q == DONE) && !hash_calc_done;
         if (word_ready) begin
            buffer_A1 <= BUF_BASE + word_idx[ADDR_W-1:0];
            buffer_I1 <= word_data;
            word_idx  <= word_idx + WIDX_W'(1);
         end
         if (start_load) begin
            word_idx <= '0;
            err_len  <= 1'b0;
         end else if (set_err) begin
            err_len <= 1'b1;
         end
      end
   end

`ifdef IMG_LOADER_CHECKSUM_EN
   logic [15:0] checksum_q;

   // Running 16-bit sum of accepted pixels, restarted by each new image
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         checksum_q <= '0;
      end else if (start_load) begin
         checksum_q <= '0;
      end else if (accept) begin
         checksum_q <= checksum_q + 16'(pix_data);
      end
   end

   assign image_checksum = checksum_q;
`else
   assign image_checksum = '0;
`endif

endmodule

// File: tb/tb_image_loader.sv
// Self-checking bench for image_loader (IMAGE_WORDS=4, BUF_BASE=12'h100).
// Expected SRAM writes are queued when a stream is driven and popped by a
// monitor whenever the DUT writes; status outputs are checked per image.
module tb_image_loader;

   localparam int          IMAGE_WORDS = 4;
   localparam int          IMAGE_PIX   = IMAGE_WORDS * 4;
   localparam logic [11:0] BUF_BASE    = 12'h100;

   typedef struct packed {
      logic [11:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_start, pix_valid, pix_last, hash_calc_done;
   logic [7:0]  pix_data;
   logic        pix_ready, buffer_WEB1, image_buffer_valid, err_len;
   logic [11:0] buffer_A1;
   logic [31:0] buffer_I1;
   logic [15:0] image_checksum;

   int  testsRun = 0;
   int  testsFailed = 0;
   int  cycleCount = 0;
   int  startCycle = 0;
   int  lastWriteCycle = 0;
   int  minSpacing = 4;
   bit  haveLastWrite = 0;
   logic        expErr;
   logic [15:0] expSum;
   wr_t sbQ[$];

   image_loader #(.IMAGE_WORDS(IMAGE_WORDS), .BUF_BASE(BUF_BASE)) dut (
      .clk                (clk),
      .reset              (reset),
      .load_start         (load_start),
      .pix_valid          (pix_valid),
      .pix_data           (pix_data),
      .pix_last           (pix_last),
      .pix_ready          (pix_ready),
      .buffer_A1          (buffer_A1),
      .buffer_I1          (buffer_I1),
      .buffer_WEB1        (buffer_WEB1),
      .image_buffer_valid (image_buffer_valid),
      .hash_calc_done     (hash_calc_done),
      .err_len            (err_len),
      .image_checksum     (image_checksum)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Cycle counter used for latency and write-spacing checks
   always @(posedge clk) cycleCount++;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [7:0] pixVal(input int p, input bit fillFf);
      return fillFf ? 8'hFF : 8'(p);
   endfunction

   // Write monitor: every SRAM write must match the head of the scoreboard
   always @(negedge clk) begin
      wr_t e;
      if (!reset && buffer_WEB1 === 1'b0) begin
         if (sbQ.size() == 0) begin
            checkOutput("unexpected_write", 32'(sbQ.size()), 32'd1);
         end else begin
            e = sbQ.pop_front();
            checkOutput("write_addr", 32'(buffer_A1), 32'(e.addr));
            checkOutput("write_data", buffer_I1, e.data);
            if (haveLastWrite)
               checkOutput("write_spacing", 32'((cycleCount - lastWriteCycle) >= minSpacing), 32'd1);
         end
         haveLastWrite  = 1'b1;
         lastWriteCycle = cycleCount;
      end
   end

   // Pulse load_start for one cycle; called and returns at posedge+1
   task automatic startLoad(input int spacing);
      minSpacing    = spacing;
      haveLastWrite = 1'b0;
      startCycle    = cycleCount;
      load_start    = 1'b1;
      @(posedge clk); #1;
      load_start    = 1'b0;
   endtask

   // Queue the expected writes for a stream, then drive it over valid/ready
   task automatic applyStimulus(input int numPix, input int lastAt,
                                input bit gaps, input bit fillFf);
      bit   endedByLast;
      int   acc, nWords, p, cyc;
      logic hs;
      logic [31:0] d;
      wr_t  w;
      endedByLast = (lastAt >= 0) && (lastAt < IMAGE_PIX);
      acc    = endedByLast ? lastAt + 1 : numPix;
      nWords = endedByLast ? (acc + 3) / 4 : acc / 4;
      expErr = endedByLast ? (lastAt != IMAGE_PIX - 1) : (acc == IMAGE_PIX);
      expSum = '0;
      for (int i = 0; i < acc; i++) expSum = expSum + 16'(pixVal(i, fillFf));
`ifndef IMG_LOADER_CHECKSUM_EN
      expSum = '0;
`endif
      for (int wi = 0; wi < nWords; wi++) begin
         d = '0;
         for (int l = 0; l < 4; l++)
            if (wi * 4 + l < acc) d[l*8 +: 8] = pixVal(wi * 4 + l, fillFf);
         w.addr = BUF_BASE + 12'(wi);
         w.data = d;
         sbQ.push_back(w);
      end
      p = 0;
      cyc = 0;
      while (p < acc && cyc < 400) begin
         pix_valid = gaps ? cyc[0] : 1'b1;
         pix_data  = pixVal(p, fillFf);
         pix_last  = (p == lastAt);
         @(negedge clk);
         hs = pix_valid && pix_ready;
         @(posedge clk); #1;
         if (hs) p++;
         cyc++;
      end
      pix_valid = 1'b0;
      pix_last  = 1'b0;
      if (p < acc) checkOutput("feed_timeout", 32'(p), 32'(acc));
   endtask

   // Wait for image_buffer_valid (bounded) and check the per-image status
   task automatic finishImage(input bit checkTiming);
      int waitCyc;
      waitCyc = 0;
      while (waitCyc < 50) begin
         @(negedge clk);
         if (image_buffer_valid === 1'b1) break;
         waitCyc++;
      end
      checkOutput("valid_rise", 32'(image_buffer_valid), 32'd1);
      if (checkTiming)
         checkOutput("valid_cycle", 32'(cycleCount - startCycle), 32'(IMAGE_PIX + 3));
      checkOutput("err_len", 32'(err_len), 32'(expErr));
      checkOutput("checksum", 32'(image_checksum), 32'(expSum));
      checkOutput("ready_in_done", 32'(pix_ready), 32'd0);
      checkOutput("writes_pending", 32'(sbQ.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   // Hand the image to the hash engine, optionally with a colliding load_start
   task automatic releaseImage(input bit withLoad);
      hash_calc_done = 1'b1;
      load_start     = withLoad;
      @(posedge clk); #1;
      hash_calc_done = 1'b0;
      load_start     = 1'b0;
      @(negedge clk);
      checkOutput("valid_fall", 32'(image_buffer_valid), 32'd0);
      checkOutput("idle_ready", 32'(pix_ready), 32'd0);
      @(negedge clk);
      checkOutput("idle_stays", 32'(pix_ready), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic checkResetValues();
      checkOutput("rst_pix_ready", 32'(pix_ready), 32'd0);
      checkOutput("rst_A1", 32'(buffer_A1), 32'd0);
      checkOutput("rst_I1", buffer_I1, 32'd0);
      checkOutput("rst_WEB1", 32'(buffer_WEB1), 32'd1);
      checkOutput("rst_valid", 32'(image_buffer_valid), 32'd0);
      checkOutput("rst_err_len", 32'(err_len), 32'd0);
      checkOutput("rst_checksum", 32'(image_checksum), 32'd0);
   endtask

   // Main sequence
   initial begin
      reset = 1'b1;
      load_start = 1'b0;
      pix_valid = 1'b0;
      pix_data = '0;
      pix_last = 1'b0;
      hash_calc_done = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkResetValues();
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      $display("[TB] reset in the middle of a fill");
      startLoad(4);
      applyStimulus(7, -1, 1'b0, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      checkResetValues();
      checkOutput("rst_pending", 32'(sbQ.size()), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      $display("[TB] full image at full rate");
      startLoad(4);
      applyStimulus(IMAGE_PIX, IMAGE_PIX - 1, 1'b0, 1'b0);
      finishImage(1'b1);

      $display("[TB] load_start in DONE, then hash done with load_start");
      load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
      @(negedge clk);
      checkOutput("done_hold_valid", 32'(image_buffer_valid), 32'd1);
      checkOutput("done_hold_ready", 32'(pix_ready), 32'd0);
      @(posedge clk); #1;
      releaseImage(1'b1);

      $display("[TB] image with valid gaps");
      startLoad(8);
      applyStimulus(IMAGE_PIX, IMAGE_PIX - 1, 1'b1, 1'b0);
      finishImage(1'b0);
      releaseImage(1'b0);

      $display("[TB] early pix_last on the 6th pixel");
      startLoad(1);
      applyStimulus(IMAGE_PIX, 5, 1'b0, 1'b0);
      finishImage(1'b0);
      releaseImage(1'b0);

      $display("[TB] final pixel without pix_last");
      startLoad(4);
      applyStimulus(IMAGE_PIX, -1, 1'b0, 1'b0);
      finishImage(1'b1);
      releaseImage(1'b0);

      $display("[TB] all-0xFF image");
      startLoad(4);
      applyStimulus(IMAGE_PIX, IMAGE_PIX - 1, 1'b0, 1'b1);
      finishImage(1'b1);
      releaseImage(1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
